iob_add_seq: RTL

// - Sequential multi-operand unsigned adder: sums N operands of W bits, P operands per clock.
// - Successor to the purely combinational N-input adder chain. Trades latency for area and

---
 rtl/iob_add_seq_if.sv | 24 ++
 rtl/iob_add_seq.sv | 110 +++++++++++
 2 files changed

// File: rtl/iob_add_seq_if.sv
// Operand/result handshake bundle for iob_add_seq: packed operand vector in, sum/carry out.
// Both directions use valid/ready; a beat transfers on a rising edge where valid and ready are both high.
interface iob_add_seq_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic           in_valid_i;
  logic           in_ready_o;
  logic [N*W-1:0] in_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [W-1:0]   sum_o;
  logic           carry_o;

  modport slave (
    input  in_valid_i, in_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, carry_o
  );

  modport master (
    output in_valid_i, in_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, carry_o
  );
endinterface

// File: rtl/iob_add_seq.sv
// Sequential multi-operand unsigned adder: sums N W-bit operands, P per clock, behind valid/ready.
// Optional macro IOB_ADD_SEQ_SAT_EN saturates sum_o to all-ones on overflow.
module iob_add_seq #(
  parameter int W = 8,
  parameter int N = 4,
  parameter int P = 1
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        cke_i,
  iob_add_seq_if.slave bus,
  output logic [1:0]  state_o
);
  localparam int AW = W + $clog2(N);
  localparam int IW = $clog2(N + P) + 1;

  if (P < 1 || P > N || N < 2) begin : g_bad_param
    $error("iob_add_seq: illegal parameters (need N>=2 and 1<=P<=N)");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N*W-1:0] ops_q, ops_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [AW-1:0]  acc_sum;
  logic           acc_ovf;
  logic           last_chunk;

  always_comb begin
    // Operands past N are never selected, so a partial last chunk adds zero for them.
    acc_sum = acc_q;
    for (int k = 0; k < N; k++) begin
      if (k >= int'(idx_q) && k < int'(idx_q) + P) begin
        acc_sum = acc_sum + AW'(ops_q[k*W +: W]);
      end
    end
    acc_ovf    = |acc_sum[AW-1:W];
    last_chunk = (int'(idx_q) + P) >= N;

    state_d = state_q;
    ops_d   = ops_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    if (cke_i) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            ops_d   = bus.in_i;
            acc_d   = '0;
            idx_d   = '0;
            state_d = ACC;
          end
        end
        ACC: begin
          acc_d = acc_sum;
          idx_d = idx_q + IW'(P);
          if (last_chunk) begin
            carry_d = acc_ovf;
`ifdef IOB_ADD_SEQ_SAT_EN
            sum_d   = acc_ovf ? {W{1'b1}} : acc_sum[W-1:0];
`else
            sum_d   = acc_sum[W-1:0];
`endif
            state_d = DONE;
          end
        end
        DONE: begin
          // Returning through IDLE forces one bubble before the next accept.
          if (bus.out_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      ops_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.sum_o       = sum_q;
  assign bus.carry_o     = carry_q;
  assign state_o         = state_q;
endmodule
